serial_alu: RTL
===============

Name: serial_alu

Overview:
- Parametrised, multi-cycle ALU built around a SLICE-bit datapath that is iterated over a WIDTH-bit operand pair.
- Implements the MIPS ALU-control operation set (AND, OR, ADD, SUB, SLT, NOR) with carry, overflow and zero flags.
- Uses a valid/ready handshake on input and output, so it can sit between the decode stage and writeback in a multi-cycle datapath.
- Trades latency (WIDTH/SLICE cycles) for area.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- SLICE, 1, bits processed per cycle; must divide WIDTH exactly. STEPS = WIDTH/SLICE.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request (high only in IDLE).
- op  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result registers hold a completed operation.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- cout  output  1  carry out of MSB for ADD/SUB/SLT; 0 otherwise.
- overflow  output  1  signed overflow for ADD/SUB/SLT; 0 otherwise.

Behaviour:
- Reset: one clock; rst_n is asynchronous, active-low. While rst_n=0: state=IDLE, result=0, zero=0, cout=0, overflow=0, out_valid=0, step counter=0, carry register=0. in_ready=(state==IDLE), so it reads 1 once reset is released. Reset mid-RUN or mid-DONE aborts the operation with no output.
- FSM states:
  - IDLE: in_ready=1. On a clk edge with in_valid=1: latch op, a, b; cnt=0; carry=1 if op is SUB or SLT, else 0; clear result; go to RUN.
  - RUN: each edge processes bits [cnt*SLICE +: SLICE].
    - Logical ops apply bitwise; ADD uses a+b+carry; SUB/SLT use a+~b+carry.
    - Write the slice into result (except SLT); update carry; cnt++.
    - At cnt==STEPS-1: compute cout = final carry and overflow = carry-into-MSB XOR carry-out-of-MSB.
    - For SLT, result = {0…0, less}, where less = diff_msb XOR overflow.
    - Set zero from the final result, assert out_valid, go to DONE.
  - DONE: out_valid=1; result and flags are stable. in_ready=0 and in_valid is ignored. On an edge with out_ready=1: out_valid=0, go to IDLE. No request can be accepted in that same cycle.
- Latency: if the request is accepted at edge k, out_valid is high after edge k+STEPS. Minimum issue interval is STEPS+2 cycles.
- Unsupported op codes: run the full STEPS cycles, then result=0, zero=1, cout=0, overflow=0.
- Flags:
  - cout/overflow are 0 for AND, OR, NOR and unsupported ops.
  - For SUB, cout=1 means no borrow (a >= b unsigned).
  - SLT reports overflow from the internal subtraction.
- Intermediate result bits are not guaranteed valid while out_valid=0.
- Latched operands are isolated from input changes after acceptance.

Test Plan:
- WIDTH=32, SLICE=1: ADD a=32'h7FFFFFFF, b=1 -> out_valid exactly 32 cycles after accept; result=32'h80000000, overflow=1, cout=0, zero=0.
- SUB a=5, b=5 -> result=0, zero=1, cout=1, overflow=0. Then SUB a=0, b=1 -> result=32'hFFFFFFFF, cout=0.
- SLT a=32'hFFFFFFFF, b=1 -> result=1. SLT a=32'h7FFFFFFF, b=32'h80000000 -> result=0, overflow=1. AND/OR/NOR of 32'hF0F0F0F0 and 32'h0FF00FF0 -> 32'h00F000F0 / 32'hFFF0FFF0 / 32'h000F000F.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result/flags unchanged, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE the next cycle, in_ready=1.
- Reset: assert rst_n=0 asynchronously at step 10 of an ADD -> outputs clear immediately, in_ready=1 after release, no out_valid pulse. A subsequent ADD 3+4 -> 7.
- WIDTH=32, SLICE=8: ADD 32'hFFFFFFFF+1 -> out_valid 4 cycles after accept, result=0, zero=1, cout=1, overflow=0. Op 4'b0101 -> result=0, zero=1.

Source files
------------

// File: rtl/serial_alu.sv
// Multi-cycle MIPS-style ALU: a SLICE-bit adder/logic slice is iterated WIDTH/SLICE times
// over latched operands, with valid/ready handshakes on both sides.
module serial_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned STEPS = WIDTH / SLICE;
  localparam int unsigned CntW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpSlt = 4'b0111;
  localparam logic [3:0] OpNor = 4'b1100;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              out_valid_q, out_valid_d;

  logic [31:0]       shamt;
  logic [SLICE-1:0]  a_s, b_s, b_eff, slice_res;
  logic [SLICE:0]    sum;
  logic              is_sub, is_arith, c_msb_in, slice_ovf, less, last;

  // Slice datapath: one SLICE-wide adder shared by ADD/SUB/SLT, plus bitwise logic.
  always_comb begin
    shamt     = 32'(cnt_q) * SLICE;
    a_s       = SLICE'(a_q >> shamt);
    b_s       = SLICE'(b_q >> shamt);
    is_sub    = (op_q == OpSub) || (op_q == OpSlt);
    is_arith  = is_sub || (op_q == OpAdd);
    b_eff     = is_sub ? ~b_s : b_s;
    sum       = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from the sum bit, avoids a separate low adder.
    c_msb_in  = sum[SLICE-1] ^ a_s[SLICE-1] ^ b_eff[SLICE-1];
    slice_ovf = c_msb_in ^ sum[SLICE];
    less      = sum[SLICE-1] ^ slice_ovf;
    last      = (cnt_q == CntW'(STEPS - 1));
    case (op_q)
      OpAnd:                slice_res = a_s & b_s;
      OpOr:                 slice_res = a_s | b_s;
      OpNor:                slice_res = ~(a_s | b_s);
      OpAdd, OpSub, OpSlt:  slice_res = sum[SLICE-1:0];
      default:              slice_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    result_d    = result_q;
    zero_d      = zero_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d     = op;
          a_d      = a;
          b_d      = b;
          cnt_d    = '0;
          carry_d  = (op == OpSub) || (op == OpSlt);
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        carry_d = sum[SLICE];
        cnt_d   = cnt_q + CntW'(1);
        if (op_q != OpSlt) begin
          result_d = result_q | (WIDTH'(slice_res) << shamt);
        end
        if (last) begin
          cout_d = is_arith & sum[SLICE];
          ovf_d  = is_arith & slice_ovf;
          if (op_q == OpSlt) begin
            result_d = WIDTH'(less);
          end
          zero_d      = (result_d == '0);
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule
